// File: rtl/systolic_pkg.sv
// Shared definitions for the streaming systolic matrix-multiply engine.
package systolic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Accumulator width large enough that K_MAX full-scale products never wrap.
    function automatic int calc_acc_width(input int data_width, input int k_max);
        return 2 * data_width + $clog2(k_max);
    endfunction

endpackage

// File: rtl/systolic_pe_mac.sv
// One output-stationary processing element: forwards a right and b down
// through one register each and accumulates a*b every cycle.
module systolic_pe_mac
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = calc_acc_width(16, 256)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  signed_mode,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic [DATA_WIDTH-1:0] b_out,
    output logic [ACC_WIDTH-1:0]  acc
);

    localparam int EXT = ACC_WIDTH - DATA_WIDTH;

    logic [ACC_WIDTH-1:0] a_ext;
    logic [ACC_WIDTH-1:0] b_ext;
    logic [ACC_WIDTH-1:0] prod;

    // Extend operands to the accumulator width so the truncated product is
    // correct modulo 2^ACC_WIDTH in both signed and unsigned mode.
    always_comb begin
        a_ext = {{EXT{signed_mode & a_in[DATA_WIDTH-1]}}, a_in};
        b_ext = {{EXT{signed_mode & b_in[DATA_WIDTH-1]}}, b_in};
        prod  = a_ext * b_ext;
    end

    // Operand forwarding and multiply-accumulate; clear starts a new job.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else if (clear) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else begin
            a_out <= a_in;
            b_out <= b_in;
            acc   <= acc + prod;
        end
    end

endmodule

// File: rtl/systolic_array_stream.sv
// ROWS x COLS output-stationary systolic engine computing C = A x B from a
// stream of (A column, B row) beats, with input skewing and a job FSM.
module systolic_array_stream
    import systolic_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DATA_WIDTH = 16,
    parameter int K_MAX      = 256,
    parameter int KW         = $clog2(K_MAX + 1),
    parameter int ACC_WIDTH  = calc_acc_width(DATA_WIDTH, K_MAX)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [KW-1:0]                   k_len,
    input  logic                            signed_mode,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0]      a_col,
    input  logic [COLS*DATA_WIDTH-1:0]      b_row,
    output logic                            busy,
    output logic                            done,
    output logic                            c_valid,
    output logic [ROWS*COLS*ACC_WIDTH-1:0]  c_out
);

    // Last beat needs ROWS+COLS cycles to reach and be summed by PE(ROWS-1,COLS-1).
    localparam int DRAIN_LAST = ROWS + COLS - 1;
    localparam int CW         = $clog2(ROWS + COLS) + 1;

    state_t                         state_reg, state_next;
    logic [KW-1:0]                  k_len_reg;
    logic [KW-1:0]                  beat_cnt_reg;
    logic [CW-1:0]                  drain_cnt_reg;
    logic                           signed_reg;
    logic                           done_reg;
    logic                           c_valid_reg;
    logic [ROWS*COLS*ACC_WIDTH-1:0] c_out_reg;

    logic                           start_ok;
    logic                           accept;
    logic                           clear;
    logic [KW-1:0]                  k_sat;
    logic [ROWS*COLS*ACC_WIDTH-1:0] acc_flat;

    logic [DATA_WIDTH-1:0] a_link [ROWS][COLS];
    logic [DATA_WIDTH-1:0] b_link [ROWS][COLS];

    assign k_sat  = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
    assign accept = in_valid & (state_reg == ST_LOAD);
    assign clear  = start_ok;

    // Next-state logic for the job sequencer.
    always_comb begin
        state_next = state_reg;
        start_ok   = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    start_ok   = 1'b1;
                    state_next = (k_sat == '0) ? ST_DRAIN : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept && (beat_cnt_reg + KW'(1) == k_len_reg))
                    state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_cnt_reg == CW'(DRAIN_LAST))
                    state_next = ST_DONE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Job state, counters, and result snapshot taken on DONE entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            k_len_reg     <= '0;
            beat_cnt_reg  <= '0;
            drain_cnt_reg <= '0;
            signed_reg    <= 1'b0;
            done_reg      <= 1'b0;
            c_valid_reg   <= 1'b0;
            c_out_reg     <= '0;
        end else begin
            state_reg <= state_next;
            done_reg  <= (state_reg == ST_DRAIN) && (state_next == ST_DONE);
            if (start_ok) begin
                k_len_reg    <= k_sat;
                signed_reg   <= signed_mode;
                beat_cnt_reg <= '0;
                c_valid_reg  <= 1'b0;
            end else if (accept) begin
                beat_cnt_reg <= beat_cnt_reg + KW'(1);
            end
            if (state_reg == ST_DRAIN)
                drain_cnt_reg <= drain_cnt_reg + CW'(1);
            else
                drain_cnt_reg <= '0;
            if ((state_reg == ST_DRAIN) && (state_next == ST_DONE)) begin
                c_out_reg   <= acc_flat;
                c_valid_reg <= 1'b1;
            end
        end
    end

    assign in_ready = (state_reg == ST_LOAD);
    assign busy     = (state_reg == ST_LOAD) || (state_reg == ST_DRAIN);
    assign done     = done_reg;
    assign c_valid  = c_valid_reg;
    assign c_out    = c_out_reg;

    // Row i of A is delayed i extra cycles after stage 0; bubbles inject zero.
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_a_skew
        logic [DATA_WIDTH-1:0] pipe [0:gi];
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int d = 0; d <= gi; d++) pipe[d] <= '0;
            end else if (clear) begin
                for (int d = 0; d <= gi; d++) pipe[d] <= '0;
            end else begin
                pipe[0] <= accept ? a_col[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
                for (int d = 1; d <= gi; d++) pipe[d] <= pipe[d-1];
            end
        end
        assign a_link[gi][0] = pipe[gi];
    end

    // Column j of B is delayed j extra cycles after stage 0; bubbles inject zero.
    for (genvar gi = 0; gi < COLS; gi++) begin : g_b_skew
        logic [DATA_WIDTH-1:0] pipe [0:gi];
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int d = 0; d <= gi; d++) pipe[d] <= '0;
            end else if (clear) begin
                for (int d = 0; d <= gi; d++) pipe[d] <= '0;
            end else begin
                pipe[0] <= accept ? b_row[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
                for (int d = 1; d <= gi; d++) pipe[d] <= pipe[d-1];
            end
        end
        assign b_link[0][gi] = pipe[gi];
    end

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        for (genvar gj = 0; gj < COLS; gj++) begin : g_col
            logic [DATA_WIDTH-1:0] a_fwd;
            logic [DATA_WIDTH-1:0] b_fwd;

            systolic_pe_mac #(
                .DATA_WIDTH (DATA_WIDTH),
                .ACC_WIDTH  (ACC_WIDTH)
            ) u_pe (
                .clk         (clk),
                .rst         (rst),
                .clear       (clear),
                .signed_mode (signed_reg),
                .a_in        (a_link[gi][gj]),
                .b_in        (b_link[gi][gj]),
                .a_out       (a_fwd),
                .b_out       (b_fwd),
                .acc         (acc_flat[(gi*COLS+gj)*ACC_WIDTH +: ACC_WIDTH])
            );

            if (gj < COLS - 1) begin : g_a_next
                assign a_link[gi][gj+1] = a_fwd;
            end else begin : g_a_edge
                logic [DATA_WIDTH-1:0] unused_a;
                assign unused_a = a_fwd;
            end

            if (gi < ROWS - 1) begin : g_b_next
                assign b_link[gi+1][gj] = b_fwd;
            end else begin : g_b_edge
                logic [DATA_WIDTH-1:0] unused_b;
                assign unused_b = b_fwd;
            end
        end
    end

endmodule

// File: tb/tb_systolic_array_stream.sv
// Directed bench: a 2x2 instance for small hand-checked products and a
// default 4x4 instance for full-length, zero-length and busy-start jobs.
module tb_systolic_array_stream;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    // Edge counter used to measure latencies.
    always @(posedge clk) cyc <= cyc + 1;

    // 2x2 instance signals
    logic         start2 = 0, sgn2 = 0, in_valid2 = 0;
    logic [8:0]   k_len2 = 0;
    logic         in_ready2, busy2, done2, c_valid2;
    logic [31:0]  a_col2 = 0, b_row2 = 0;
    logic [159:0] c_out2;

    // 4x4 instance signals
    logic         start4 = 0, sgn4 = 0, in_valid4 = 0;
    logic [8:0]   k_len4 = 0;
    logic         in_ready4, busy4, done4, c_valid4;
    logic [63:0]  a_col4 = 0, b_row4 = 0;
    logic [639:0] c_out4;

    // Operand tables for the 2x2 jobs: a2[i][k] = A[i][k], b2[k][j] = B[k][j]
    logic [15:0] a2 [0:1][0:1];
    logic [15:0] b2 [0:1][0:1];
    int          exp2 [0:1][0:1];

    systolic_array_stream #(.ROWS(2), .COLS(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .k_len(k_len2), .signed_mode(sgn2),
        .in_valid(in_valid2), .in_ready(in_ready2), .a_col(a_col2), .b_row(b_row2),
        .busy(busy2), .done(done2), .c_valid(c_valid2), .c_out(c_out2)
    );

    systolic_array_stream u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .k_len(k_len4), .signed_mode(sgn4),
        .in_valid(in_valid4), .in_ready(in_ready4), .a_col(a_col4), .b_row(b_row4),
        .busy(busy4), .done(done4), .c_valid(c_valid4), .c_out(c_out4)
    );

    task automatic feed2(input int k, input bit sgn, input bit bubbles, output int last_edge);
        int beat;
        int guard;
        bit tog;
        bit take;
        start2 = 1; k_len2 = 9'(k); sgn2 = sgn;
        @(posedge clk); #1;
        start2 = 0;
        beat = 0; guard = 0; tog = 1; last_edge = cyc;
        while (beat < k && guard < 200) begin
            in_valid2 = bubbles ? tog : 1'b1;
            tog = ~tog;
            a_col2 = {a2[1][beat], a2[0][beat]};
            b_row2 = {b2[beat][1], b2[beat][0]};
            take = in_valid2 && in_ready2;
            total++;
            if (in_ready2 !== 1'b1) begin
                bad++; $display("FAIL in_ready2_load got=%b want=1 beat=%0d", in_ready2, beat);
            end
            @(posedge clk); #1;
            if (take) begin beat++; last_edge = cyc; end
            guard++;
        end
        in_valid2 = 0;
        total++;
        if (beat != k) begin
            bad++; $display("FAIL feed2_timeout got=%0d beats want=%0d", beat, k);
        end
        total++;
        if (in_ready2 !== 1'b0) begin
            bad++; $display("FAIL in_ready2_after_last got=%b want=0", in_ready2);
        end
    endtask

    task automatic wait_done2(input int ref_edge, input int exp_lat, input string name);
        int guard = 0;
        while (done2 !== 1'b1 && guard < 100) begin @(posedge clk); #1; guard++; end
        $display("job %s: done at edge %0d latency %0d", name, cyc, cyc - ref_edge);
        total++;
        if (done2 !== 1'b1 || cyc - ref_edge != exp_lat) begin
            bad++; $display("FAIL %s_latency got=%0d want=%0d done=%b", name, cyc - ref_edge, exp_lat, done2);
        end
        total++;
        if (c_valid2 !== 1'b1 || busy2 !== 1'b0) begin
            bad++; $display("FAIL %s_flags got c_valid=%b busy=%b want 1/0", name, c_valid2, busy2);
        end
        @(posedge clk); #1;
        total++;
        if (done2 !== 1'b0 || c_valid2 !== 1'b1) begin
            bad++; $display("FAIL %s_pulse got done=%b c_valid=%b want 0/1", name, done2, c_valid2);
        end
    endtask

    task automatic feed4(input int k, input logic [15:0] av, input logic [15:0] bv,
                         input bit inject, output int last_edge);
        int beat;
        int guard;
        bit injected;
        start4 = 1; k_len4 = 9'(k); sgn4 = 0;
        @(posedge clk); #1;
        start4 = 0;
        beat = 0; guard = 0; injected = 0; last_edge = cyc;
        while (beat < k && guard < 2000) begin
            if (inject && !injected && beat == 1) begin
                in_valid4 = 0; start4 = 1; k_len4 = 0;
                @(posedge clk); #1;
                start4 = 0; injected = 1;
                total++;
                if (in_ready4 !== 1'b1 || busy4 !== 1'b1) begin
                    bad++; $display("FAIL busy_start_ignored got in_ready=%b busy=%b want 1/1", in_ready4, busy4);
                end
            end
            in_valid4 = 1; a_col4 = {4{av}}; b_row4 = {4{bv}};
            @(posedge clk); #1;
            beat++; last_edge = cyc;
            guard++;
        end
        in_valid4 = 0;
        total++;
        if (in_ready4 !== 1'b0) begin
            bad++; $display("FAIL in_ready4_after_last got=%b want=0", in_ready4);
        end
    endtask

    task automatic wait_done4(input int ref_edge, input int exp_lat, input string name);
        int guard = 0;
        while (done4 !== 1'b1 && guard < 100) begin @(posedge clk); #1; guard++; end
        $display("job %s: done at edge %0d latency %0d", name, cyc, cyc - ref_edge);
        total++;
        if (done4 !== 1'b1 || cyc - ref_edge != exp_lat) begin
            bad++; $display("FAIL %s_latency got=%0d want=%0d done=%b", name, cyc - ref_edge, exp_lat, done4);
        end
        total++;
        if (c_valid4 !== 1'b1) begin
            bad++; $display("FAIL %s_c_valid got=%b want=1", name, c_valid4);
        end
    endtask

    task automatic test_reset();
        total++;
        if (in_ready2 !== 0 || busy2 !== 0 || done2 !== 0 || c_valid2 !== 0 || c_out2 !== '0) begin
            bad++; $display("FAIL reset2 got rdy=%b busy=%b done=%b cv=%b c=%h want zeros",
                            in_ready2, busy2, done2, c_valid2, c_out2);
        end
        total++;
        if (in_ready4 !== 0 || busy4 !== 0 || done4 !== 0 || c_valid4 !== 0 || c_out4 !== '0) begin
            bad++; $display("FAIL reset4 got rdy=%b busy=%b done=%b cv=%b want zeros",
                            in_ready4, busy4, done4, c_valid4);
        end
    endtask

    task automatic load_ab_unsigned();
        a2[0][0] = 1; a2[0][1] = 2; a2[1][0] = 3; a2[1][1] = 4;
        b2[0][0] = 5; b2[0][1] = 6; b2[1][0] = 7; b2[1][1] = 8;
        exp2[0][0] = 19; exp2[0][1] = 22; exp2[1][0] = 43; exp2[1][1] = 50;
    endtask

    task automatic test_unsigned_2x2(input bit bubbles, input string name);
        int last;
        load_ab_unsigned();
        feed2(2, 1'b0, bubbles, last);
        wait_done2(last, 4, name);
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                total++;
                if (c_out2[(i*2+j)*40 +: 40] !== 40'(exp2[i][j])) begin
                    bad++; $display("FAIL %s_c%0d%0d got=%0d want=%0d", name, i, j,
                                    c_out2[(i*2+j)*40 +: 40], exp2[i][j]);
                end
            end
    endtask

    task automatic test_signed();
        int last;
        a2[0][0] = -16'sd3; a2[1][0] = 16'sd2;
        b2[0][0] = 16'sd4;  b2[0][1] = -16'sd5;
        exp2[0][0] = -12; exp2[0][1] = 15; exp2[1][0] = 8; exp2[1][1] = -10;
        feed2(1, 1'b1, 1'b0, last);
        wait_done2(last, 4, "signed");
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                total++;
                if (c_out2[(i*2+j)*40 +: 40] !== 40'(exp2[i][j])) begin
                    bad++; $display("FAIL signed_c%0d%0d got=%h want=%h", i, j,
                                    c_out2[(i*2+j)*40 +: 40], 40'(exp2[i][j]));
                end
            end
    endtask

    task automatic test_full_k();
        int last;
        logic [39:0] want = 40'hFF_FE00_0100;
        feed4(256, 16'hFFFF, 16'hFFFF, 1'b0, last);
        wait_done4(last, 8, "full_k");
        for (int n = 0; n < 16; n++) begin
            total++;
            if (c_out4[n*40 +: 40] !== want) begin
                bad++; $display("FAIL full_k_c%0d got=%h want=%h", n, c_out4[n*40 +: 40], want);
            end
        end
    endtask

    task automatic test_zero_k_and_busy_start();
        int last;
        logic [39:0] six = 40'd6;
        @(posedge clk); #1;
        feed4(0, 16'd0, 16'd0, 1'b0, last);
        wait_done4(last, 8, "zero_k");
        total++;
        if (c_out4 !== '0) begin
            bad++; $display("FAIL zero_k_c got=%h want=0", c_out4[159:0]);
        end
        @(posedge clk); #1;
        feed4(3, 16'd1, 16'd2, 1'b1, last);
        wait_done4(last, 8, "busy_start");
        for (int n = 0; n < 16; n++) begin
            total++;
            if (c_out4[n*40 +: 40] !== six) begin
                bad++; $display("FAIL busy_start_c%0d got=%0d want=6", n, c_out4[n*40 +: 40]);
            end
        end
    endtask

    task automatic test_reset_in_drain();
        int last;
        bit saw_done = 0;
        load_ab_unsigned();
        feed2(2, 1'b0, 1'b0, last);
        @(posedge clk); #3;
        rst = 0;
        #1;
        total++;
        if (busy2 !== 0 || done2 !== 0 || c_valid2 !== 0 || in_ready2 !== 0 || c_out2 !== '0) begin
            bad++; $display("FAIL reset_drain2 got busy=%b done=%b cv=%b rdy=%b want zeros",
                            busy2, done2, c_valid2, in_ready2);
        end
        total++;
        if (c_valid4 !== 0 || c_out4 !== '0) begin
            bad++; $display("FAIL reset_drain4 got cv=%b want 0 with zero c_out", c_valid4);
        end
        @(posedge clk); #1;
        rst = 1;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            if (done2 === 1'b1) saw_done = 1;
        end
        total++;
        if (saw_done) begin
            bad++; $display("FAIL reset_no_done got done=1 want none after abort");
        end
        test_unsigned_2x2(1'b0, "after_reset");
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1;
        @(posedge clk); #1;
        test_unsigned_2x2(1'b0, "unsigned");
        test_unsigned_2x2(1'b1, "bubbles");
        test_signed();
        test_full_k();
        test_zero_k_and_busy_start();
        test_reset_in_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/systolic_array_stream.md
Name: systolic_array_stream

Overview:
- Parametrised, output-stationary ROWS x COLS systolic matrix-multiply engine computing C = A x B, with A of size ROWS x K and B of size K x COLS.
- Successor to the fixed square 8x8 array. Adds rectangular shape, runtime K length, signed/unsigned mode, internal input skewing, a valid/ready input handshake with bubble tolerance, and a start/busy/done job FSM.
- Sits between the operand-streaming front end and the result-collection logic.

Parameters:
- ROWS, 4, number of PE rows (A vector length).
- COLS, 4, number of PE columns (B vector length).
- DATA_WIDTH, 16, operand width.
- K_MAX, 256, maximum inner dimension per job.
- KW, $clog2(K_MAX+1), width of k_len.
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(K_MAX), accumulator width per PE.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  job start pulse; honoured only in IDLE or DONE.
- k_len  in  KW  inner dimension K; sampled on start.
- signed_mode  in  1  1 = two's-complement operands; sampled on start.
- in_valid  in  1  a_col and b_row both valid.
- in_ready  out  1  engine accepts a beat.
- a_col  in  ROWS*DATA_WIDTH  column k of A; row i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- b_row  in  COLS*DATA_WIDTH  row k of B; column j occupies bits [j*DATA_WIDTH +: DATA_WIDTH].
- busy  out  1  high in LOAD or DRAIN.
- done  out  1  one-cycle pulse on DONE entry.
- c_valid  out  1  c_out holds the final result of the last job.
- c_out  out  ROWS*COLS*ACC_WIDTH  C[i][j] occupies bits [(i*COLS+j)*ACC_WIDTH +: ACC_WIDTH].

Behaviour:
- Reset (rst=0, async): state IDLE; in_ready, busy, done, c_valid = 0; c_out, all accumulators and all skew/pipe registers = 0.
- FSM states: IDLE, LOAD, DRAIN, DONE.
  - IDLE/DONE + start: clear all accumulators and skew registers; latch k_len and signed_mode; clear beat counter; c_valid <= 0. Next state is LOAD, or DRAIN if k_len==0.
  - LOAD: in_ready=1. A beat is accepted on in_valid & in_ready. After beat number k_len is accepted, go to DRAIN. in_ready drops the cycle after the last beat.
  - DRAIN: counter runs ROWS+COLS-1 cycles, then go to DONE.
  - DONE: done=1 for the entry cycle only; c_valid=1 until the next start; c_out holds its value.
- start outside IDLE/DONE is ignored. k_len > K_MAX is saturated to K_MAX.
- Dataflow:
  - An accepted beat is registered into skew stage 0.
  - Row i of A passes through i extra registers and enters PE(i,0). Column j of B passes through j extra registers and enters PE(0,j).
  - Each PE forwards a right and b down with one register each, and does acc <= acc + a*b every cycle.
  - Cycles without acceptance inject zero into stage 0 (bubble). Products stay aligned per beat, so sums are unaffected.
- Timing: a beat accepted at edge T contributes to PE(i,j) at edge T+1+i+j. c_out is snapshotted from the accumulators on the DONE-entry edge. Latency from the last-beat acceptance edge to done high is ROWS+COLS cycles.
- Arithmetic: in signed_mode, operands are sign-extended to ACC_WIDTH before the multiply; otherwise zero-extended. The accumulator wraps modulo 2^ACC_WIDTH. With the default sizing, overflow cannot occur for K <= K_MAX.
- Edge cases:
  - k_len==0: c_out is all zeros; done fires ROWS+COLS cycles after start.
  - start in the same cycle as done: accepted, and the new job begins.
  - Reset mid-job: everything returns to reset values immediately; no done is generated.
  - in_valid held low in LOAD: the engine waits indefinitely with no timeout.

Decomposition:
- Package systolic_pkg: state encoding (IDLE, LOAD, DRAIN, DONE) and an ACC_WIDTH helper function.
- One sub-module, systolic_pe_mac: a/b forwarding registers, clear input, signed_mode input, acc output. It is instantiated in a ROWS x COLS generate grid.

Test Plan:
1. ROWS=COLS=2, unsigned, K=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], in_valid held high -> C=[[19,22],[43,50]]; done exactly 4 cycles after the last accept edge; c_valid stays high.
2. Same operands with in_valid toggling every other cycle (bubbles) -> identical C; in_ready deasserts after the 2nd beat.
3. Signed mode, K=1, a=[-3,2], b=[4,-5] -> C=[[-12,15],[8,-10]] in ACC_WIDTH two's complement.
4. Defaults 4x4, K=256, all operands 0xFFFF unsigned -> every C = 256*0xFFFE0001, with no wrap.
5. k_len=0 -> c_out all zeros; done 8 cycles after start. A start issued while busy in a subsequent job is ignored (state and count unchanged).
6. rst asserted during DRAIN -> all outputs are 0 at once. A fresh job after reset yields results with no carry-over from the aborted job.
